// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Types and constants shared by the simple CPU blocks.
//   pm_state_t      : program memory sequencing states (clear sweep / load)
//   PM_MODE_APPEND  : loader writes at the next free index, stops when full
//   PM_MODE_SHIFT   : loader shifts words toward index 0, newest at the top
//   INSTR_WIDTH     : default instruction word width
// ---------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic {
      PM_CLEAR,
      PM_LOAD
   } pm_state_t;

   localparam logic PM_MODE_APPEND = 1'b0;
   localparam logic PM_MODE_SHIFT  = 1'b1;

   localparam int INSTR_WIDTH = 12;

endpackage

// File: rtl/program_memory.sv
// ---------------------------------------------------------------------------
// program_memory
// Instruction store between the program loader and the CPU fetch stage.
// After reset or a clear request every word is zeroed by a DEPTH-cycle sweep;
// the store is then loaded word-by-word in APPEND or SHIFT mode (mode sampled
// from shift_mode when the sweep finishes).
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : restart the clear sweep
//   shift_mode   : 1 = SHIFT load mode, 0 = APPEND
//   load_valid   : loader presents load_data
//   load_data    : instruction word to store
//   load_ready   : word is accepted this cycle when load_valid is high
//   rd_index     : combinational read address
//   rd_data      : mem[rd_index], 0 while busy or out of range
//   fetch_en     : registered fetch request (ignored while busy)
//   fetch_addr   : registered fetch address
//   fetch_data   : word registered from fetch_addr, 1-cycle latency
//   count        : number of valid words, 0..DEPTH
//   full         : count == DEPTH
//   busy         : clear sweep in progress
// ---------------------------------------------------------------------------
module program_memory
   import cpu_pkg::*;
#(
   parameter int WIDTH  = INSTR_WIDTH,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              shift_mode,
   input  logic              load_valid,
   input  logic [WIDTH-1:0]  load_data,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] rd_index,
   output logic [WIDTH-1:0]  rd_data,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [WIDTH-1:0]  fetch_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              busy
);

   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   pm_state_t         state;
   pm_state_t         state_next;
   logic [ADDR_W-1:0] clr_ptr;
   logic [ADDR_W:0]   count_q;
   logic              mode_q;
   logic [WIDTH-1:0]  fetch_q;
   logic [WIDTH-1:0]  mem [DEPTH];

   logic              xfer;
   logic              rd_in_range;
   logic              fetch_in_range;
   logic              clr_last;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= PM_CLEAR;
      else       state <= state_next;
   end

   // ---------------- next state and outputs ----------------
   always_comb begin
      state_next     = state;
      busy           = 1'b0;
      load_ready     = 1'b0;
      clr_last       = (clr_ptr == LAST_PTR);
      full           = (count_q == DEPTH_C);
      rd_in_range    = ({1'b0, rd_index} < DEPTH_C);
      fetch_in_range = ({1'b0, fetch_addr} < DEPTH_C);

      case (state)
         PM_CLEAR: begin
            busy = 1'b1;
            if (!clear && clr_last) state_next = PM_LOAD;
         end
         PM_LOAD: begin
            // SHIFT mode keeps accepting when full; the oldest word falls off.
            load_ready = !clear && ((mode_q == PM_MODE_SHIFT) || !full);
            if (clear) state_next = PM_CLEAR;
         end
         default: state_next = PM_CLEAR;
      endcase

      xfer    = load_valid && load_ready && !reset;
      rd_data = (busy || !rd_in_range) ? '0 : mem[rd_index];
   end

   // ---------------- sweep pointer, word count, load mode ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_ptr <= '0;
         count_q <= '0;
         mode_q  <= PM_MODE_APPEND;
      end else if (clear) begin
         clr_ptr <= '0;
         count_q <= '0;
      end else if (state == PM_CLEAR) begin
         // Explicit wrap so non-power-of-two DEPTH ends on the last word.
         clr_ptr <= clr_last ? '0 : clr_ptr + 1'b1;
         if (clr_last) mode_q <= shift_mode;
      end else if (xfer && (count_q != DEPTH_C)) begin
         count_q <= count_q + 1'b1;
      end
   end

   // ---------------- storage (no reset; zeroed by the clear sweep) ----------------
   always_ff @(posedge clk) begin
      if (!reset && state == PM_CLEAR) begin
         mem[clr_ptr] <= '0;
      end else if (xfer) begin
         if (mode_q == PM_MODE_SHIFT) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
               mem[ADDR_W'(i)] <= mem[ADDR_W'(i + 1)];
            end
            mem[LAST_PTR] <= load_data;
         end else begin
            mem[count_q[ADDR_W-1:0]] <= load_data;
         end
      end
   end

   // ---------------- registered fetch port ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_q <= '0;
      end else if (state == PM_LOAD && fetch_en) begin
         fetch_q <= fetch_in_range ? mem[fetch_addr] : '0;
      end
   end

   always_comb begin
      count      = count_q;
      fetch_data = fetch_q;
   end

endmodule

// File: tb/tb_program_memory.sv
module tb_program_memory;
   import cpu_pkg::*;

   localparam int WIDTH  = INSTR_WIDTH;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              reset, clear, shift_mode, load_valid, fetch_en;
   logic [WIDTH-1:0]  load_data;
   logic              load_ready, full, busy;
   logic [ADDR_W-1:0] rd_index, fetch_addr;
   logic [WIDTH-1:0]  rd_data, fetch_data;
   logic [ADDR_W:0]   count;

   always #5 clk = ~clk;

   program_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .clear(clear), .shift_mode(shift_mode),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .rd_index(rd_index), .rd_data(rd_data),
      .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
      .count(count), .full(full), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural reference: word list, valid count, clear cycles remaining.
   logic [WIDTH-1:0] m_mem [DEPTH];
   int               m_count     = 0;
   int               m_busy_left = 0;
   logic             m_mode      = 1'b0;
   logic [WIDTH-1:0] m_fetch     = '0;

   function automatic logic exp_ready();
      return (m_busy_left == 0) && !clear && (m_mode || (m_count < DEPTH));
   endfunction

   function automatic logic [WIDTH-1:0] exp_rd(input int idx);
      if (m_busy_left > 0 || idx >= DEPTH) return '0;
      return m_mem[idx];
   endfunction

   // Advance the model by one edge from the current inputs, then step the clock.
   task automatic tick();
      logic [WIDTH-1:0] q [$];
      bit do_xfer;
      do_xfer = load_valid && exp_ready();
      if (reset) begin
         m_busy_left = DEPTH; m_count = 0; m_fetch = '0; m_mode = 1'b0;
         foreach (m_mem[i]) m_mem[i] = '0;
      end else begin
         if (m_busy_left == 0 && fetch_en)
            m_fetch = (int'(fetch_addr) < DEPTH) ? m_mem[fetch_addr] : '0;
         if (clear) begin
            m_busy_left = DEPTH; m_count = 0;
            foreach (m_mem[i]) m_mem[i] = '0;
         end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_mode = shift_mode;
         end else if (do_xfer) begin
            if (m_mode) begin
               q.delete();
               foreach (m_mem[i]) q.push_back(m_mem[i]);
               void'(q.pop_front());
               q.push_back(load_data);
               foreach (m_mem[i]) m_mem[i] = q[i];
               if (m_count < DEPTH) m_count++;
            end else begin
               m_mem[m_count] = load_data;
               m_count++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; clear = 1'b0; shift_mode = PM_MODE_APPEND;
      load_valid = 1'b0; load_data = '0; fetch_en = 1'b0; fetch_addr = '0; rd_index = '0;
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         rd_index = ADDR_W'($urandom_range(0, DEPTH - 1));
         #1;
         total++; if (busy !== (i < DEPTH)) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b want=%b", i, busy, (i < DEPTH)); end
         total++; if (load_ready !== (i == DEPTH)) begin bad++; $display("FAIL reset_ready cyc=%0d got=%b want=%b", i, load_ready, (i == DEPTH)); end
         total++; if (rd_data !== exp_rd(int'(rd_index))) begin bad++; $display("FAIL reset_rd cyc=%0d got=%h want=%h", i, rd_data, exp_rd(int'(rd_index))); end
         total++; if (count !== '0 || full !== 1'b0) begin bad++; $display("FAIL reset_count cyc=%0d got=%0d/%b want=0/0", i, count, full); end
         total++; if (fetch_data !== '0) begin bad++; $display("FAIL reset_fetch cyc=%0d got=%h want=0", i, fetch_data); end
         if (i < DEPTH) tick();
      end
   endtask

   task automatic test_append();
      for (int i = 0; i < DEPTH; i++) begin
         load_valid = 1'b1; load_data = WIDTH'(12'h101 + i);
         #1;
         total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL append_ready i=%0d got=%b want=1", i, load_ready); end
         tick();
         total++; if (count !== (ADDR_W + 1)'(i + 1)) begin bad++; $display("FAIL append_count i=%0d got=%0d want=%0d", i, count, i + 1); end
         total++; if (full !== (i == DEPTH - 1)) begin bad++; $display("FAIL append_full i=%0d got=%b want=%b", i, full, (i == DEPTH - 1)); end
      end
      load_data = 12'h1FF;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL append_holdoff i=%0d got=%b want=0", i, load_ready); end
         tick();
         total++; if (count !== (ADDR_W + 1)'(m_count) || m_count != DEPTH) begin bad++; $display("FAIL append_sat i=%0d got=%0d want=%0d", i, count, DEPTH); end
      end
      load_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_index = ADDR_W'(i);
         #1;
         total++; if (rd_data !== exp_rd(i)) begin bad++; $display("FAIL append_rd idx=%0d got=%h want=%h", i, rd_data, exp_rd(i)); end
      end
      fetch_en = 1'b1; fetch_addr = 3'd5;
      tick();
      fetch_en = 1'b0;
      total++; if (fetch_data !== m_fetch) begin bad++; $display("FAIL append_fetch got=%h want=%h", fetch_data, m_fetch); end
   endtask

   task automatic test_reset_when_full();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (fetch_data !== '0) begin bad++; $display("FAIL rstfull_fetch got=%h want=0", fetch_data); end
      total++; if (count !== '0 || load_ready !== 1'b0) begin bad++; $display("FAIL rstfull_state got=%0d/%b want=0/0", count, load_ready); end
      for (int i = 0; i < DEPTH; i++) begin
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstfull_busy cyc=%0d got=%b want=1", i, busy); end
         tick();
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstfull_done got=%b want=0", busy); end
   endtask

   task automatic test_shift();
      shift_mode = PM_MODE_SHIFT; clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL shift_clrbusy cyc=%0d got=%b want=1", i, busy); end
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         load_valid = 1'b1; load_data = WIDTH'(i + 1);
         #1;
         total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL shift_ready i=%0d got=%b want=1", i, load_ready); end
         tick();
         total++; if (count !== (ADDR_W + 1)'((i + 1 < DEPTH) ? i + 1 : DEPTH)) begin bad++; $display("FAIL shift_count i=%0d got=%0d want=%0d", i, count, m_count); end
      end
      load_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_index = ADDR_W'(i);
         #1;
         total++; if (rd_data !== exp_rd(i)) begin bad++; $display("FAIL shift_rd idx=%0d got=%h want=%h", i, rd_data, exp_rd(i)); end
      end
   endtask

   task automatic test_clear_priority();
      load_valid = 1'b1; load_data = 12'hABC; clear = 1'b1;
      #1;
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL clrpri_ready got=%b want=0", load_ready); end
      tick();
      clear = 1'b0; load_valid = 1'b0;
      total++; if (count !== '0 || busy !== 1'b1) begin bad++; $display("FAIL clrpri_start got=%0d/%b want=0/1", count, busy); end
      for (int i = 0; i < DEPTH; i++) tick();
      total++; if (busy !== 1'b0 || count !== '0) begin bad++; $display("FAIL clrpri_done got=%b/%0d want=0/0", busy, count); end
      for (int i = 0; i < DEPTH; i++) begin
         rd_index = ADDR_W'(i);
         #1;
         total++; if (rd_data !== exp_rd(i)) begin bad++; $display("FAIL clrpri_rd idx=%0d got=%h want=%h", i, rd_data, exp_rd(i)); end
      end
   endtask

   task automatic test_fetch_collision();
      logic [WIDTH-1:0] old3;
      load_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         load_data = WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
         tick();
      end
      old3 = m_mem[3];
      fetch_en = 1'b1; fetch_addr = 3'd3; load_data = 12'h5A5;
      tick();
      load_valid = 1'b0;
      total++; if (fetch_data !== old3) begin bad++; $display("FAIL collide_old got=%h want=%h", fetch_data, old3); end
      tick();
      fetch_en = 1'b0;
      total++; if (fetch_data !== m_mem[3]) begin bad++; $display("FAIL collide_new got=%h want=%h", fetch_data, m_mem[3]); end
   endtask

   task automatic test_reset_mid_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (fetch_data !== '0) begin bad++; $display("FAIL midclr_fetch got=%h want=0", fetch_data); end
      for (int i = 0; i < DEPTH; i++) begin
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL midclr_busy cyc=%0d got=%b want=1", i, busy); end
         tick();
      end
      total++; if (busy !== 1'b0 || load_ready !== 1'b1) begin bad++; $display("FAIL midclr_done got=%b/%b want=0/1", busy, load_ready); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         reset      = ($urandom_range(0, 99) == 0);
         clear      = ($urandom_range(0, 39) == 0);
         shift_mode = 1'($urandom_range(0, 1));
         load_valid = ($urandom_range(0, 3) != 0);
         load_data  = WIDTH'($urandom);
         fetch_en   = 1'($urandom_range(0, 1));
         fetch_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
         rd_index   = ADDR_W'($urandom_range(0, DEPTH - 1));
         #1;
         total++; if (load_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, load_ready, exp_ready()); end
         total++; if (busy !== (m_busy_left > 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, (m_busy_left > 0)); end
         total++; if (count !== (ADDR_W + 1)'(m_count) || full !== (m_count == DEPTH)) begin bad++; $display("FAIL rnd_count c=%0d got=%0d/%b want=%0d", c, count, full, m_count); end
         total++; if (rd_data !== exp_rd(int'(rd_index))) begin bad++; $display("FAIL rnd_rd c=%0d idx=%0d got=%h want=%h", c, rd_index, rd_data, exp_rd(int'(rd_index))); end
         total++; if (fetch_data !== m_fetch) begin bad++; $display("FAIL rnd_fetch c=%0d got=%h want=%h", c, fetch_data, m_fetch); end
         tick();
      end
      reset = 1'b0; clear = 1'b0; load_valid = 1'b0; fetch_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_append();
      test_reset_when_full();
      test_shift();
      test_clear_priority();
      test_fetch_collision();
      test_reset_mid_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
